rate_encoder: RTL and testbench

Deterministic rate-coding spike generator that sits directly upstream of if_neuron and drives its spike_in bus. Each channel holds an intensity value written through a small memory-style port. On each timestep of a run, the intensity is added into a per-channel phase accumulator, and a spike is emitted on overflow. Spike count over N steps is exactly floor(I*N / 2^INTENSITY_WIDTH), which gives benches exact expected values.

---
 rtl/rate_encoder.sv | 144 ++++++++++++++
 tb/tb_rate_encoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_encoder.sv
// -----------------------------------------------------------------------------
// rate_encoder
// Deterministic rate-coding spike generator feeding if_neuron's spike_in bus.
// Each channel holds an intensity; during a run the intensity is added into a
// per-channel phase accumulator once per timestep and the carry out is the
// spike. Over N steps a channel emits exactly floor(I*N / 2^INTENSITY_WIDTH)
// spikes.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mem_addr   intensity register address
//   mem_din    intensity write data
//   mem_wen    intensity write enable (dropped while busy)
//   mem_dout   registered read data for mem_addr (one-cycle latency)
//   start      begin a run (sampled in IDLE or DONE only)
//   num_steps  run length in timesteps, latched at start
//   busy       high while running
//   done       one-cycle pulse when a run completes
//   spike_out  registered spike vector, one bit per channel
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; intensity writes accepted
// RUN    | one timestep per clock; writes dropped, start ignored
// DONE   | one-cycle completion pulse; last step's spikes visible
// -----------------------------------------------------------------------------
module rate_encoder #(
    parameter int NUM_INPUTS      = 4,
    parameter int INTENSITY_WIDTH = 8,
    parameter int ADDR_WIDTH      = 2,
    parameter int STEP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [INTENSITY_WIDTH-1:0] mem_din,
    input  logic                       mem_wen,
    output logic [INTENSITY_WIDTH-1:0] mem_dout,
    input  logic                       start,
    input  logic [STEP_WIDTH-1:0]      num_steps,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_INPUTS-1:0]      spike_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [INTENSITY_WIDTH-1:0] intensity_q [NUM_INPUTS];
    logic [INTENSITY_WIDTH-1:0] intensity_d [NUM_INPUTS];
    logic [INTENSITY_WIDTH-1:0] acc_q [NUM_INPUTS];
    logic [INTENSITY_WIDTH-1:0] acc_d [NUM_INPUTS];
    logic [STEP_WIDTH-1:0]      steps_left_q, steps_left_d;
    logic [INTENSITY_WIDTH-1:0] mem_dout_q, mem_dout_d;
    logic [NUM_INPUTS-1:0]      spike_out_q, spike_out_d;
    logic [INTENSITY_WIDTH:0]   sum;

    always_comb begin
        state_d      = state_q;
        intensity_d  = intensity_q;
        acc_d        = acc_q;
        steps_left_d = steps_left_q;
        spike_out_d  = spike_out_q;
        mem_dout_d   = '0;
        sum          = '0;

        // Read returns the pre-write value; unmatched addresses read as 0.
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (mem_addr == ADDR_WIDTH'(i)) begin
                mem_dout_d = intensity_q[i];
            end
        end

        if (mem_wen && (state_q != S_RUN)) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (mem_addr == ADDR_WIDTH'(i)) begin
                    intensity_d[i] = mem_din;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        acc_d[i] = '0;
                    end
                    spike_out_d  = '0;
                    steps_left_d = num_steps;
                    state_d      = (num_steps == '0) ? S_DONE : S_RUN;
                end else if (state_q == S_DONE) begin
                    spike_out_d = '0;
                    state_d     = S_IDLE;
                end
            end
            S_RUN: begin
                // Carry out of the phase accumulator is the spike.
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    sum            = {1'b0, acc_q[i]} + {1'b0, intensity_q[i]};
                    acc_d[i]       = sum[INTENSITY_WIDTH-1:0];
                    spike_out_d[i] = sum[INTENSITY_WIDTH];
                end
                steps_left_d = steps_left_q - STEP_WIDTH'(1);
                if (steps_left_q == STEP_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            steps_left_q <= '0;
            mem_dout_q   <= '0;
            spike_out_q  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                intensity_q[i] <= '0;
                acc_q[i]       <= '0;
            end
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            mem_dout_q   <= mem_dout_d;
            spike_out_q  <= spike_out_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                intensity_q[i] <= intensity_d[i];
                acc_q[i]       <= acc_d[i];
            end
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign mem_dout  = mem_dout_q;
    assign spike_out = spike_out_q;

endmodule

// File: tb/tb_rate_encoder.sv
// -----------------------------------------------------------------------------
// tb_rate_encoder
// Self-checking bench for rate_encoder. Expected spikes come from the
// closed-form rule: with accumulators cleared at start, channel i spikes at
// step k exactly when floor(I*k/256) > floor(I*(k-1)/256).
// -----------------------------------------------------------------------------
module tb_rate_encoder;

    localparam int NI = 4;
    localparam int W  = 8;
    localparam int AW = 2;
    localparam int SW = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic          mem_wen;
    logic [W-1:0]  mem_dout;
    logic          start;
    logic [SW-1:0] num_steps;
    logic          busy;
    logic          done;
    logic [NI-1:0] spike_out;

    int total;
    int bad;
    int model_int [NI];

    rate_encoder #(
        .NUM_INPUTS      (NI),
        .INTENSITY_WIDTH (W),
        .ADDR_WIDTH      (AW),
        .STEP_WIDTH      (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wen   (mem_wen),
        .mem_dout  (mem_dout),
        .start     (start),
        .num_steps (num_steps),
        .busy      (busy),
        .done      (done),
        .spike_out (spike_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NI-1:0] exp_spikes(input int k);
        logic [NI-1:0] v;
        v = '0;
        for (int i = 0; i < NI; i++) begin
            v[i] = ((model_int[i] * k) / 256) > ((model_int[i] * (k - 1)) / 256);
        end
        return v;
    endfunction

    task automatic wr(input int addr, input int data);
        mem_addr = AW'(addr);
        mem_din  = W'(data);
        mem_wen  = 1'b1;
        step();
        mem_wen  = 1'b0;
        if (addr < NI) model_int[addr] = data;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_out !== '0) begin
            bad++;
            $display("FAIL %s idle: busy=%b done=%b spike=%b, want 0 0 0000", name, busy, done, spike_out);
        end
    endtask

    // Caller sets start/num_steps before calling; the first edge here latches
    // the start. Returns with the DUT in its DONE cycle.
    task automatic run_and_check(input int n, input string name, input int wr_step,
                                 output int cnt [NI]);
        int busy_cycles;
        logic [NI-1:0] e;
        for (int i = 0; i < NI; i++) cnt[i] = 0;
        busy_cycles = 0;
        step();
        start = 1'b0;
        if (n == 0) begin
            total++;
            if (busy !== 1'b0 || done !== 1'b1 || spike_out !== '0) begin
                bad++;
                $display("FAIL %s zero-len: busy=%b done=%b spike=%b, want 0 1 0000", name, busy, done, spike_out);
            end
            return;
        end
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || spike_out !== '0) begin
            bad++;
            $display("FAIL %s launch: busy=%b done=%b spike=%b, want 1 0 0000", name, busy, done, spike_out);
        end
        busy_cycles = 1;
        for (int k = 1; k <= n; k++) begin
            if (k == wr_step) begin
                mem_addr = AW'(3);
                mem_din  = 8'h11;
                mem_wen  = 1'b1;
            end
            step();
            mem_wen = 1'b0;
            e = exp_spikes(k);
            if (busy) busy_cycles++;
            for (int i = 0; i < NI; i++) cnt[i] += int'(spike_out[i]);
            total++;
            if (spike_out !== e) begin
                bad++;
                $display("FAIL %s spikes step %0d: got %b want %b", name, k, spike_out, e);
            end
            total++;
            if (done !== (k == n) || busy !== (k != n)) begin
                bad++;
                $display("FAIL %s status step %0d: busy=%b done=%b want busy=%b done=%b",
                         name, k, busy, done, k != n, k == n);
            end
        end
        total++;
        if (busy_cycles != n) begin
            bad++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cycles, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; mem_wen = 1'b1; mem_addr = '0; mem_din = 8'hAA; num_steps = 16'd5;
        step(); step(); step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_out !== '0 || mem_dout !== '0) begin
            bad++;
            $display("FAIL reset hold: busy=%b done=%b spike=%b dout=%h, want all 0", busy, done, spike_out, mem_dout);
        end
        start = 1'b0; mem_wen = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) model_int[i] = 0;
        for (int a = 0; a < NI; a++) begin
            mem_addr = AW'(a);
            step();
            total++;
            if (mem_dout !== '0) begin
                bad++;
                $display("FAIL reset readback addr %0d: got %h want 00", a, mem_dout);
            end
        end
    endtask

    task automatic test_write_readback();
        int vals [NI] = '{0, 64, 128, 255};
        for (int a = 0; a < NI; a++) wr(a, vals[a]);
        for (int a = 0; a < NI; a++) begin
            mem_addr = AW'(a);
            step();
            total++;
            if (mem_dout !== W'(vals[a])) begin
                bad++;
                $display("FAIL readback addr %0d: got %h want %h", a, mem_dout, vals[a]);
            end
        end
        check_idle("readback");
    endtask

    task automatic test_rate_run();
        int cnt [NI];
        int want [NI] = '{0, 2, 4, 7};
        start = 1'b1; num_steps = 16'd8;
        run_and_check(8, "rate", 3, cnt);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (cnt[i] != want[i]) begin
                bad++;
                $display("FAIL rate count ch%0d: got %0d want %0d", i, cnt[i], want[i]);
            end
        end
        step();
        check_idle("rate end");
        mem_addr = AW'(3);
        step();
        total++;
        if (mem_dout !== 8'hFF) begin
            bad++;
            $display("FAIL write-while-busy addr 3: got %h want ff", mem_dout);
        end
    endtask

    task automatic test_zero_length();
        int cnt [NI];
        start = 1'b1; num_steps = 16'd0;
        run_and_check(0, "zero", 0, cnt);
        step();
        check_idle("zero end");
    endtask

    task automatic test_abort();
        int cnt [NI];
        int want [NI] = '{0, 2, 4, 7};
        start = 1'b1; num_steps = 16'd100;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL abort pre step %0d: busy=%b done=%b want 1 0", k, busy, done);
            end
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_out !== '0) begin
            bad++;
            $display("FAIL abort async: busy=%b done=%b spike=%b want 0 0 0000", busy, done, spike_out);
        end
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) model_int[i] = 0;
        step();
        check_idle("abort after");
        wr(0, 0); wr(1, 64); wr(2, 128); wr(3, 255);
        start = 1'b1; num_steps = 16'd8;
        run_and_check(8, "abort rerun", 0, cnt);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (cnt[i] != want[i]) begin
                bad++;
                $display("FAIL abort rerun count ch%0d: got %0d want %0d", i, cnt[i], want[i]);
            end
        end
        step();
        check_idle("abort rerun end");
    endtask

    task automatic test_back_to_back();
        int cnt [NI];
        start = 1'b1; num_steps = 16'd2;
        run_and_check(2, "b2b first", 0, cnt);
        start = 1'b1; num_steps = 16'd4;
        run_and_check(4, "b2b second", 0, cnt);
        total++;
        if (cnt[2] != 2) begin
            bad++;
            $display("FAIL b2b ch2 count: got %0d want 2", cnt[2]);
        end
        step();
        check_idle("b2b end");
    endtask

    task automatic test_random();
        int cnt [NI];
        int n;
        int ch;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NI; i++) wr(i, int'($urandom_range(0, 255)));
            // Write lands on the same edge as start and must be used from step 1.
            ch = int'($urandom_range(0, NI - 1));
            mem_addr = AW'(ch);
            mem_din  = W'($urandom_range(0, 255));
            mem_wen  = 1'b1;
            model_int[ch] = int'(mem_din);
            n = (r == 0) ? 0 : int'($urandom_range(1, 40));
            num_steps = SW'(n);
            start = 1'b1;
            run_and_check(n, "random", int'($urandom_range(1, 5)), cnt);
            mem_wen = 1'b0;
            for (int i = 0; i < NI; i++) begin
                total++;
                if (cnt[i] != (model_int[i] * n) / 256) begin
                    bad++;
                    $display("FAIL random count ch%0d I=%0d N=%0d: got %0d want %0d",
                             i, model_int[i], n, cnt[i], (model_int[i] * n) / 256);
                end
            end
            step();
            check_idle("random end");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; start = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_din = '0; num_steps = '0;
        for (int i = 0; i < NI; i++) model_int[i] = 0;
        test_reset();
        test_write_readback();
        test_rate_run();
        test_zero_length();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
